// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and decode helpers for the pipelined RV32I controller
//
// Purpose : opcode constants, control-field encodings and the E-stage control
//           bundle carried through the pipe_ctrl stage registers.
// Ports   : none (package).
// Config  : PIPE_CTRL_FWD_EN is consumed by pipe_ctrl, not by this package.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01
  } pcsrc_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_e   alu_ctrl;
    logic        alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // sub only exists for R-type; callers pass sub=0 for I-ALU so "subi" reads as addi.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// rtl/pipe_ctrl_decode.sv - combinational main decoder for the D stage
//
// Purpose : maps opcode/funct3/funct7[5] to control fields and immediate format.
//           Unknown opcodes decode as a NOP (no writes, no control transfer).
// Ports   : opcode_i, funct3_i, funct7b5_i   instruction fields
//           reg_write_o, result_src_o, mem_write_o, jump_o, branch_o,
//           alu_ctrl_o, alu_src_o, imm_src_o  decoded control
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic       mem_write_o,
  output logic       jump_o,
  output logic       branch_o,
  output logic [2:0] alu_ctrl_o,
  output logic       alu_src_o,
  output logic [1:0] imm_src_o
);

  always_comb begin
    reg_write_o  = 1'b0;
    result_src_o = RES_ALU;
    mem_write_o  = 1'b0;
    jump_o       = 1'b0;
    branch_o     = 1'b0;
    alu_ctrl_o   = ALU_ADD;
    alu_src_o    = 1'b0;
    imm_src_o    = IMM_I;
    case (opcode_i)
      OP_LW: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_MEM;
        alu_src_o    = 1'b1;
      end
      OP_SW: begin
        mem_write_o = 1'b1;
        alu_src_o   = 1'b1;
        imm_src_o   = IMM_S;
      end
      OP_R: begin
        reg_write_o = 1'b1;
        alu_ctrl_o  = alu_decode(funct3_i, funct7b5_i);
      end
      OP_I: begin
        reg_write_o = 1'b1;
        alu_src_o   = 1'b1;
        alu_ctrl_o  = alu_decode(funct3_i, 1'b0);
      end
      OP_BEQ: begin
        branch_o   = 1'b1;
        alu_ctrl_o = ALU_SUB;
        imm_src_o  = IMM_B;
      end
      OP_JAL: begin
        jump_o       = 1'b1;
        reg_write_o  = 1'b1;
        result_src_o = RES_PC4;
        imm_src_o    = IMM_J;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage RV32I pipeline controller with hazard unit
//
// Purpose : decodes instrD, carries control D->E->M->W, and produces stall,
//           flush and forwarding selects for the datapath.
// Ports   : clk, reset (async, active-low)
//           instrD, zeroE                      inputs from the datapath
//           imm_srcD, alu_srcE, alu_controlE, pcsrcE,
//           mem_writeM, reg_writeW, result_srcW datapath control
//           stallF, stallD, flushD, flushE     hazard control
//           forwardAE, forwardBE               operand forwarding selects
// Config  : PIPE_CTRL_FWD_EN defined   -> M/W forwarding to E operands.
//           PIPE_CTRL_FWD_EN undefined -> no forwarding; any RAW on an
//           in-flight writer (E, M or W) stalls D.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic        zeroE,
  output logic [1:0]  imm_srcD,
  output logic        alu_srcE,
  output logic [2:0]  alu_controlE,
  output logic [1:0]  pcsrcE,
  output logic        mem_writeM,
  output logic        reg_writeW,
  output logic [1:0]  result_srcW,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE
);

  logic [RA_W-1:0] rs1D, rs2D, rdD;
  assign rs1D = instrD[15 +: RA_W];
  assign rs2D = instrD[20 +: RA_W];
  assign rdD  = instrD[7 +: RA_W];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instrD[31], instrD[29:25]};

  logic       dec_reg_write, dec_mem_write, dec_jump, dec_branch, dec_alu_src;
  logic [1:0] dec_result_src;
  logic [2:0] dec_alu_ctrl;

  ctrl_decode u_decode (
    .opcode_i     (instrD[6:0]),
    .funct3_i     (instrD[14:12]),
    .funct7b5_i   (instrD[30]),
    .reg_write_o  (dec_reg_write),
    .result_src_o (dec_result_src),
    .mem_write_o  (dec_mem_write),
    .jump_o       (dec_jump),
    .branch_o     (dec_branch),
    .alu_ctrl_o   (dec_alu_ctrl),
    .alu_src_o    (dec_alu_src),
    .imm_src_o    (imm_srcD)
  );

  ctrl_t ctrlD;
  always_comb begin
    ctrlD            = CTRL_NOP;
    ctrlD.reg_write  = dec_reg_write;
    ctrlD.result_src = result_src_e'(dec_result_src);
    ctrlD.mem_write  = dec_mem_write;
    ctrlD.jump       = dec_jump;
    ctrlD.branch     = dec_branch;
    ctrlD.alu_ctrl   = alu_ctrl_e'(dec_alu_ctrl);
    ctrlD.alu_src    = dec_alu_src;
  end

  // Stage registers
  ctrl_t           ctrlE_q, ctrlE_d;
  logic [RA_W-1:0] rdE_q, rdE_d;
  logic            reg_writeM_q, mem_writeM_q;
  result_src_e     result_srcM_q;
  logic [RA_W-1:0] rdM_q;
  logic            reg_writeW_q;
  result_src_e     result_srcW_q;
  logic [RA_W-1:0] rdW_q;

  logic taken;
  logic load_use;
  logic raw_stall;
  logic hazard_stall;

  // A bubble is a fully cleared E entry, including rdE, so it can neither
  // write nor match anything downstream.
  always_comb begin
    ctrlE_d = flushE ? CTRL_NOP : ctrlD;
    rdE_d   = flushE ? '0 : rdD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlE_q       <= CTRL_NOP;
      rdE_q         <= '0;
      reg_writeM_q  <= 1'b0;
      mem_writeM_q  <= 1'b0;
      result_srcM_q <= RES_ALU;
      rdM_q         <= '0;
      reg_writeW_q  <= 1'b0;
      result_srcW_q <= RES_ALU;
      rdW_q         <= '0;
    end else begin
      ctrlE_q       <= ctrlE_d;
      rdE_q         <= rdE_d;
      reg_writeM_q  <= ctrlE_q.reg_write;
      mem_writeM_q  <= ctrlE_q.mem_write;
      result_srcM_q <= ctrlE_q.result_src;
      rdM_q         <= rdE_q;
      reg_writeW_q  <= reg_writeM_q;
      result_srcW_q <= result_srcM_q;
      rdW_q         <= rdM_q;
    end
  end

  assign alu_srcE     = ctrlE_q.alu_src;
  assign alu_controlE = ctrlE_q.alu_ctrl;
  assign mem_writeM   = mem_writeM_q;
  assign reg_writeW   = reg_writeW_q;
  assign result_srcW  = result_srcW_q;

  assign taken  = ctrlE_q.jump | (ctrlE_q.branch & zeroE);
  assign pcsrcE = taken ? PC_TARGET : PC_PLUS4;

  // Raw rs fields are compared for every format; a spurious stall on an
  // I/J-type garbage field only costs a cycle.
  assign load_use = (ctrlE_q.result_src == RES_MEM) && (rdE_q != '0) &&
                    ((rdE_q == rs1D) || (rdE_q == rs2D));

`ifdef PIPE_CTRL_FWD_EN
  logic [RA_W-1:0] rs1E_q, rs2E_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1E_q <= '0;
      rs2E_q <= '0;
    end else begin
      rs1E_q <= flushE ? '0 : rs1D;
      rs2E_q <= flushE ? '0 : rs2D;
    end
  end

  // M is the younger producer, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic rw_m, input logic [RA_W-1:0] rd_m,
                                         input logic rw_w, input logic [RA_W-1:0] rd_w);
    if (rw_m && (rd_m != '0) && (rd_m == rs)) return 2'b10;
    if (rw_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign forwardAE = fwd_sel(rs1E_q, reg_writeM_q, rdM_q, reg_writeW_q, rdW_q);
  assign forwardBE = fwd_sel(rs2E_q, reg_writeM_q, rdM_q, reg_writeW_q, rdW_q);
  assign raw_stall = 1'b0;
`else
  // Without forwarding the register file is the only source, and it is not
  // write-through, so a writer still sitting in W must also hold D.
  function automatic logic raw_hit(input logic [RA_W-1:0] rs);
    if (rs == '0) return 1'b0;
    return (ctrlE_q.reg_write && (rdE_q == rs)) ||
           (reg_writeM_q && (rdM_q == rs)) ||
           (reg_writeW_q && (rdW_q == rs));
  endfunction

  assign forwardAE = 2'b00;
  assign forwardBE = 2'b00;
  assign raw_stall = raw_hit(rs1D) | raw_hit(rs2D);
`endif

  // A taken transfer makes the D instruction wrong-path, so flush overrides stall.
  assign hazard_stall = load_use | raw_stall;
  assign stallF       = hazard_stall & ~taken;
  assign stallD       = hazard_stall & ~taken;
  assign flushD       = taken;
  assign flushE       = taken | hazard_stall;

endmodule
